// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) supplies decode/stage fields and memory status.
// The controller side (slave) returns enables, flushes, PC select and statistics.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       i_id_rs;
    logic [4:0]       i_id_rt;
    logic             i_id_uses_rt;
    logic             i_ex_memread;
    logic [4:0]       i_ex_rt;
    logic             i_mem_branch;
    logic             i_mem_zero;
    logic             i_mem_access;
    logic             i_dmem_ack;
    logic             i_halt_req;
    logic             i_cnt_clr;

    logic             o_pc_en;
    logic             o_if_id_en;
    logic             o_id_ex_en;
    logic             o_ex_mem_en;
    logic             o_mem_wb_en;
    logic             o_if_id_flush;
    logic             o_id_ex_flush;
    logic             o_ex_mem_flush;
    logic             o_pc_sel;
    logic             o_dmem_req;
    logic             o_halted;
    logic             o_mem_err;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_memread, i_ex_rt,
               i_mem_branch, i_mem_zero, i_mem_access, i_dmem_ack,
               i_halt_req, i_cnt_clr,
        input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_pc_sel,
               o_dmem_req, o_halted, o_mem_err, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_memread, i_ex_rt,
               i_mem_branch, i_mem_zero, i_mem_access, i_dmem_ack,
               i_halt_req, i_cnt_clr,
        output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_pc_sel,
               o_dmem_req, o_halted, o_mem_err, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU.
// Mealy control: enables/flushes are combinational from state and inputs so a
// hazard is handled in the cycle it appears. A three-state FSM sequences the
// data-memory wait and debug halt; saturating counters track stalls/flushes.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALTED} state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_err;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    state_t              w_state_nxt;
    logic                w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic                w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;
    logic                w_pc_sel, w_dmem_req, w_halted;
    logic                w_run_rules, w_mem_done, w_freeze;
    logic                w_timeout, w_branch, w_load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_timeout  = (r_state == S_MEM_WAIT) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign w_branch   = bus.i_mem_branch & bus.i_mem_zero;
    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_load_use = bus.i_ex_memread && (bus.i_ex_rt != 5'd0) &&
                        ((bus.i_ex_rt == bus.i_id_rs) ||
                         (bus.i_id_uses_rt && (bus.i_ex_rt == bus.i_id_rt)));

    // Next state and Mealy outputs; release cycles of MEM_WAIT/HALTED fall through to the RUN rules.
    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_mem_wb_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_pc_sel       = 1'b0;
        w_dmem_req     = 1'b0;
        w_halted       = 1'b0;
        w_state_nxt    = r_state;
        w_run_rules    = 1'b0;
        w_mem_done     = 1'b0;
        w_freeze       = 1'b0;

        case (r_state)
            S_RUN: w_run_rules = 1'b1;
            S_MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (bus.i_dmem_ack || w_timeout) begin
                    w_run_rules = 1'b1;
                    w_mem_done  = 1'b1;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            S_HALTED: begin
                if (bus.i_halt_req) begin
                    w_freeze = 1'b1;
                    w_halted = 1'b1;
                end else begin
                    w_run_rules = 1'b1;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase

        if (w_run_rules) begin
            w_state_nxt = S_RUN;
            if (bus.i_mem_access) w_dmem_req = 1'b1;
            if (bus.i_mem_access && !bus.i_dmem_ack && !w_mem_done) begin
                w_freeze    = 1'b1;
                w_state_nxt = S_MEM_WAIT;
            end else if (bus.i_halt_req) begin
                w_freeze    = 1'b1;
                w_halted    = 1'b1;
                w_state_nxt = S_HALTED;
            end else if (w_branch) begin
                // One flush cycle kills the three younger instructions.
                w_pc_sel       = 1'b1;
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
                w_ex_mem_flush = 1'b1;
            end else if (w_load_use) begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
            end
        end

        if (w_freeze) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
        end
    end

    // FSM state, memory wait counter and sticky timeout flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_MEM_WAIT) && !w_mem_done) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout && !bus.i_dmem_ack) r_mem_err <= 1'b1;
        end
    end

    // Saturating stall/flush statistics; clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.i_cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_pc_sel) r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

    // Strobes drop as soon as reset asserts, independent of the clock.
    assign bus.o_pc_en        = i_rst_n & w_pc_en;
    assign bus.o_if_id_en     = i_rst_n & w_if_id_en;
    assign bus.o_id_ex_en     = i_rst_n & w_id_ex_en;
    assign bus.o_ex_mem_en    = i_rst_n & w_ex_mem_en;
    assign bus.o_mem_wb_en    = i_rst_n & w_mem_wb_en;
    assign bus.o_if_id_flush  = i_rst_n & w_if_id_flush;
    assign bus.o_id_ex_flush  = i_rst_n & w_id_ex_flush;
    assign bus.o_ex_mem_flush = i_rst_n & w_ex_mem_flush;
    assign bus.o_pc_sel       = i_rst_n & w_pc_sel;
    assign bus.o_dmem_req     = i_rst_n & w_dmem_req;
    assign bus.o_halted       = i_rst_n & w_halted;
    assign bus.o_mem_err      = r_mem_err;
    assign bus.o_stall_cnt    = r_stall_cnt;
    assign bus.o_flush_cnt    = r_flush_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage pipeline CPU. It produces the per-stage load-enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. It detects load-use hazards and taken branches, and sequences a data-memory wait handshake. It also supports an external halt request and keeps saturating stall and flush statistics.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum number of MEM_WAIT cycles before the controller forces release.
- CNT_W, 16: width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_id_rs, i_id_rt  in  5 each  source register fields of the instruction in IF/ID.
- i_id_uses_rt  in  1  the ID instruction reads rt as a source.
- i_ex_memread  in  1  ID/EX MEM_control[1], a load is in EX.
- i_ex_rt  in  5  ID/EX target register.
- i_mem_branch  in  1  EX/MEM MEM_control[2].
- i_mem_zero  in  1  EX/MEM zero flag.
- i_mem_access  in  1  EX/MEM MEM_control[1] or MEM_control[0].
- i_dmem_ack  in  1  data memory has completed the current access.
- i_halt_req  in  1  level-sensitive debug halt request.
- i_cnt_clr  in  1  synchronous clear of the statistics counters.
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage register load enables.
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush  out  1 each  the register loads all-zero (a bubble) at the next edge.
- o_pc_sel  out  1  the PC loads the branch target from EX/MEM.
- o_dmem_req  out  1  data memory access request.
- o_halted  out  1  the pipeline is frozen by a halt.
- o_mem_err  out  1  sticky flag, set when MEM_TIMEOUT expires.
- o_stall_cnt, o_flush_cnt  out  CNT_W each  saturating statistics counters.

## Operation
- State machine with three states: RUN, MEM_WAIT, HALTED. Reset state is RUN.
- Outputs are Mealy: combinational from the current state and inputs, so a hazard is acted on in the cycle it appears.
- Define freeze as all five enables low and all flushes low.

Causes, evaluated in RUN in priority order:
1. **Memory wait.** When i_mem_access=1:
   - o_dmem_req=1.
   - If i_dmem_ack=0: freeze, and go to MEM_WAIT.
   - If i_dmem_ack=1: no freeze from this cause; evaluate the lower-priority causes.
2. **Halt.** When i_halt_req=1: freeze and go to HALTED.
3. **Taken branch.** When i_mem_branch & i_mem_zero:
   - o_pc_sel=1.
   - Assert o_if_id_flush, o_id_ex_flush and o_ex_mem_flush.
   - All enables high.
4. **Load-use hazard.** Condition: i_ex_memread, and i_ex_rt≠0, and either i_ex_rt==i_id_rs or (i_id_uses_rt and i_ex_rt==i_id_rt). Response:
   - o_pc_en=0 and o_if_id_en=0.
   - o_id_ex_flush=1.
   - o_ex_mem_en=1 and o_mem_wb_en=1.
5. Otherwise all enables are 1 and all flushes are 0.

State behaviour:
- **MEM_WAIT**
  - o_dmem_req=1 and the pipeline stays frozen.
  - A wait counter increments every cycle.
  - On i_dmem_ack=1, or when the counter reaches MEM_TIMEOUT: go to RUN and clear the wait counter.
  - That cycle's outputs are computed as in RUN, with the memory cause treated as satisfied.
  - On timeout, additionally set o_mem_err.
- **HALTED**
  - Freeze, o_halted=1.
  - When i_halt_req=0: go to RUN; outputs that cycle follow the RUN rules.

Counters and flags:
- o_stall_cnt increments every cycle in which o_pc_en=0. o_flush_cnt increments every cycle in which o_pc_sel=1.
- Both counters saturate at all-ones.
- i_cnt_clr zeroes both counters and has priority over increment.
- o_mem_err is cleared only by reset.

## Timing
- While i_rst_n=0: all enables, flushes, o_pc_sel, o_dmem_req and o_halted are 0.
- Reset values of registered outputs: state=RUN, counters=0, o_mem_err=0, wait counter=0.
- Hazard response latency is 0 cycles, because the outputs are combinational.
- Flushes take effect at the next i_clk edge.
- A load-use stall lasts exactly 1 cycle: after the bubble the load has left EX, so the condition clears naturally.
- A taken branch costs 3 bubbles, produced by a single flush cycle.
- A branch and a load-use hazard in the same cycle: the branch wins, the flush kills the dependent instruction, and o_pc_en stays 1.
- A memory wait together with a branch: freeze first; the branch is honoured on the ack cycle.
- i_halt_req during MEM_WAIT is ignored until the access completes.
- A load-use hazard with i_ex_rt=0 never stalls.
- Reset asserted mid-wait or mid-halt returns to RUN immediately, without waiting for a clock edge.

## Test plan
- **Load-use:** i_ex_memread=1, i_ex_rt=5, i_id_rs=5 → for one cycle o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; o_stall_cnt goes 0→1. Repeat with i_ex_rt=0 → no stall.
- **Branch taken:** i_mem_branch=1, i_mem_zero=1 → o_pc_sel=1 and all three flushes=1 for one cycle; o_flush_cnt=1. With i_mem_zero=0 → no action.
- **Memory wait:** i_mem_access=1, ack low for 4 cycles then high → o_dmem_req=1 for 5 cycles; freeze for 4 cycles; enables high on the ack cycle; o_stall_cnt=4.
- **Timeout:** MEM_TIMEOUT=8, ack never asserted → release after 8 MEM_WAIT cycles, o_mem_err=1 and it stays 1.
- **Halt:** i_halt_req pulses high for 3 cycles during RUN → o_halted=1 and freeze for 3 cycles, resume on the 4th. A halt raised during MEM_WAIT takes effect only after the ack.
- **Reset and saturation:** assert i_rst_n=0 mid MEM_WAIT → outputs reset asynchronously. Preload o_stall_cnt to 0xFFFF and stall → it stays 0xFFFF. Assert i_cnt_clr → the counter reads 0 at the next edge.
